hazard_irq_ctrl: RTL
====================

// Module: hazard_irq_ctrl
// PURPOSE
// - Parametrised successor of the 5-stage pipeline hazard unit (IF/ID/EX/MEM/WB).
// - Resolves load-use hazards for multi-cycle data memory through a stall counter.
// - Resolves WB→ID register-file hazards and BTB mispredicts, as before.
// - Adds an interrupt-entry sequencer: drains in-flight instructions, saves EPC, then redirects to the trap vector.
// PARAMETERS
// - XLEN      32  datapath / PC width
// - REG_AW    5   register address width
// - LOAD_LAT  1   load-use stall cycles (1..15); 1 = single-cycle DMEM
// - IRQ_DRAIN 3   cycles spent draining EX/MEM/WB before EPC save (1..7)
// PORTS
// - i_clk          in   1       clock, rising edge
// - i_rst_n        in   1       reset, asynchronous, active-low
// - i_ex_rd_wren   in   1       EX-stage rd write enable; same for i_wb_rd_wren (WB stage)
// - i_ex_rd_addr   in   REG_AW  EX rd; same for i_wb_rd_addr
// - i_id_rs1_addr  in   REG_AW  ID rs1; same for i_id_rs2_addr
// - i_id_opcode    in   7       ID opcode; same for i_ex_opcode
// - i_pc_sel       in   1       EX resolved taken
// - i_pc_sel_BTB   in   1       predicted taken
// - i_alu_data     in   XLEN    EX resolved target
// - i_pc_BTB       in   XLEN    predicted target
// - i_id_pc        in   XLEN    PC of instruction in ID
// - i_irq_req      in   1       level interrupt request, held until o_irq_ack
// - stall_ID/EX/MEM/WB out 1    stage enable, active-low (0 = hold)
// - flush_ID/EX/MEM/WB out 1    stage flush, active-low (0 = bubble)
// - pc_enable      out  1       PC register enable
// - restore_pc     out  1       select resolved EX target/PC+4
// - o_trap_sel     out  1       select trap vector as next PC
// - o_epc_wren     out  1       EPC write strobe
// - o_epc          out  XLEN    EPC value
// - o_irq_ack      out  1       one-cycle interrupt acknowledge
// - o_busy         out  1       sequencer not IDLE
// - o_stall_cnt    out  32      performance counter (see CONFIGURATION)
// - o_flush_cnt    out  32      performance counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset outputs and state:
//   - stall_*/flush_* = 1; pc_enable = 1.
//   - restore_pc, o_trap_sel, o_epc_wren, o_irq_ack, o_busy = 0; o_epc = 0; counters = 0.
//   - FSM = IDLE; ld_cnt = 0.
// - rs2 is used only for R-, S- and B-type. Register x0 never hazards.
// - Load-use hazard: EX is a load (0000011) and its rd matches a used ID rs.
//   - Detection cycle stalls and loads ld_cnt = LOAD_LAT-1.
//   - Stall holds while ld_cnt != 0, decrementing each cycle; total stall = LOAD_LAT cycles.
//   - Each stall cycle: stall_ID = 0, pc_enable = 0, flush_EX = 0.
// - WB hazard: WB rd matches a used ID rs. One-cycle stall, same outputs, no counter.
// - Mispredict (EX is B/JAL/JALR):
//   - Condition: taken differs from prediction, or both taken and i_alu_data != i_pc_BTB.
//   - Response: flush_ID = 0, flush_EX = 0, restore_pc = 1, and ld_cnt is cleared.
//   - The killed ID instruction releases any stall.
//   - If a WB hazard coincides, pc_enable = 0 and stall_ID = 0 as well.
// - Interrupt FSM: IDLE → DRAIN → SAVE → REDIRECT → IDLE.
//   - IDLE: i_irq_req = 1 and ld_cnt == 0 → capture epc_q = i_id_pc, load drn_cnt = IRQ_DRAIN-1, go to DRAIN.
//   - IRQ arriving during a load stall waits until ld_cnt == 0.
//   - DRAIN: pc_enable = 0, flush_ID = 0; EX/MEM/WB run; drn_cnt decrements; drn_cnt == 0 → SAVE.
//   - Mispredict during DRAIN: epc_q takes the resolved target (i_alu_data if taken, else the branch PC+4).
//   - Mispredict during DRAIN does not assert restore_pc.
//   - SAVE: o_epc_wren = 1, o_epc = epc_q, pc_enable = 0 → REDIRECT.
//   - REDIRECT: o_trap_sel = 1, pc_enable = 1, o_irq_ack = 1, flush_ID = 0 → IDLE.
//   - An irq still high one cycle after ack is treated as a new request.
//   - o_busy = 1 in DRAIN, SAVE and REDIRECT; hazard outputs are suppressed there except flush_EX on mispredict.
// - Reset asserted mid-sequence: immediate return to IDLE, all outputs at reset values, no ack issued.
// CONFIGURATION
// - HAZARD_PERF_CNT_EN defined:
//   - o_stall_cnt increments on every cycle with stall_ID = 0.
//   - o_flush_cnt increments on every cycle with flush_EX = 0.
//   - Both counters saturate at 32'hFFFF_FFFF.
// - HAZARD_PERF_CNT_EN undefined: both outputs tied to 0 and no counter flops are built.
// TESTING
// - LOAD_LAT=3; lw x5 in EX, add x6,x5,x1 in ID → stall_ID = 0 for exactly 3 cycles, flush_EX = 0 each cycle.
// - Mispredict: BTB predicts not taken, i_pc_sel = 1, i_alu_data = 0x100 → restore_pc = 1, flush_ID = flush_EX = 0 for one cycle.
// - Mispredict during load stall (ld_cnt = 2) → ld_cnt = 0, stall_ID = 1 the next cycle.
// - IRQ: i_id_pc = 0x40, IRQ_DRAIN = 3 → o_epc_wren at cycle 4 with o_epc = 0x40; o_trap_sel and o_irq_ack at cycle 5.
// - IRQ with taken mispredict to 0x200 at DRAIN cycle 1 → o_epc = 0x200.
// - i_rst_n low during SAVE → o_epc_wren = 0 immediately; o_busy = 0; no o_irq_ack.

Source files
------------

// File: rtl/hazard_irq_ctrl.sv
// Pipeline hazard unit (load-use, WB->ID, mispredict) with an interrupt-entry sequencer.
// Optional saturating performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_irq_ctrl #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int IRQ_DRAIN = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ex_rd_wren,
    input  logic [REG_AW-1:0] i_ex_rd_addr,
    input  logic              i_wb_rd_wren,
    input  logic [REG_AW-1:0] i_wb_rd_addr,
    input  logic [REG_AW-1:0] i_id_rs1_addr,
    input  logic [REG_AW-1:0] i_id_rs2_addr,
    input  logic [6:0]        i_id_opcode,
    input  logic [6:0]        i_ex_opcode,
    input  logic              i_pc_sel,
    input  logic              i_pc_sel_BTB,
    input  logic [XLEN-1:0]   i_alu_data,
    input  logic [XLEN-1:0]   i_pc_BTB,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic              i_irq_req,
    output logic              stall_ID,
    output logic              stall_EX,
    output logic              stall_MEM,
    output logic              stall_WB,
    output logic              flush_ID,
    output logic              flush_EX,
    output logic              flush_MEM,
    output logic              flush_WB,
    output logic              pc_enable,
    output logic              restore_pc,
    output logic              o_trap_sel,
    output logic              o_epc_wren,
    output logic [XLEN-1:0]   o_epc,
    output logic              o_irq_ack,
    output logic              o_busy,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_flush_cnt
);

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [1:0] {IDLE, DRAIN, SAVE, REDIRECT} state_t;

    state_t            state;
    logic [3:0]        ld_cnt;
    logic [2:0]        drn_cnt;
    logic [XLEN-1:0]   epc_q;
    logic [XLEN-1:0]   ex_pc;
    logic              busy_q;
    logic              epc_wren_q;
    logic              trap_sel_q;
    logic              irq_ack_q;

    logic              rs2_used;
    logic              ld_hit;
    logic              wb_hit;
    logic              ex_ctrl;
    logic              mispredict;
    logic              ld_stall;
    logic              irq_take;
    logic [XLEN-1:0]   resolved_pc;

    // x0 never hazards; only R/S/B instructions read rs2. Write enables qualify both producers.
    assign rs2_used = (i_id_opcode == OP_R) || (i_id_opcode == OP_S) || (i_id_opcode == OP_B);

    assign ld_hit = (i_ex_opcode == OP_LOAD) && i_ex_rd_wren && (i_ex_rd_addr != '0) &&
                    ((i_ex_rd_addr == i_id_rs1_addr) ||
                     (rs2_used && (i_ex_rd_addr == i_id_rs2_addr)));

    assign wb_hit = i_wb_rd_wren && (i_wb_rd_addr != '0) &&
                    ((i_wb_rd_addr == i_id_rs1_addr) ||
                     (rs2_used && (i_wb_rd_addr == i_id_rs2_addr)));

    assign ex_ctrl    = (i_ex_opcode == OP_B) || (i_ex_opcode == OP_JAL) || (i_ex_opcode == OP_JALR);
    assign mispredict = ex_ctrl &&
                        ((i_pc_sel != i_pc_sel_BTB) ||
                         (i_pc_sel && i_pc_sel_BTB && (i_alu_data != i_pc_BTB)));

    assign ld_stall    = (ld_cnt != '0) || ld_hit;
    assign irq_take    = (state == IDLE) && i_irq_req && (ld_cnt == '0);
    assign resolved_pc = i_pc_sel ? i_alu_data : (ex_pc + XLEN'(4));

    // Stage controls: hazard responses in IDLE, sequencer overrides while busy.
    always_comb begin
        stall_ID   = 1'b1;
        stall_EX   = 1'b1;
        stall_MEM  = 1'b1;
        stall_WB   = 1'b1;
        flush_ID   = 1'b1;
        flush_EX   = 1'b1;
        flush_MEM  = 1'b1;
        flush_WB   = 1'b1;
        pc_enable  = 1'b1;
        restore_pc = 1'b0;
        if (!i_rst_n) begin
            stall_ID = 1'b1;
        end else if (state == IDLE) begin
            if (mispredict) begin
                flush_ID   = 1'b0;
                flush_EX   = 1'b0;
                restore_pc = 1'b1;
                if (wb_hit) begin
                    pc_enable = 1'b0;
                    stall_ID  = 1'b0;
                end
            end else if (ld_stall || wb_hit) begin
                stall_ID  = 1'b0;
                pc_enable = 1'b0;
                flush_EX  = 1'b0;
            end
        end else begin
            if (mispredict) begin
                flush_EX = 1'b0;
            end
            case (state)
                DRAIN: begin
                    pc_enable = 1'b0;
                    flush_ID  = 1'b0;
                end
                SAVE: begin
                    pc_enable = 1'b0;
                end
                REDIRECT: begin
                    flush_ID = 1'b0;
                end
                default: begin
                    pc_enable = 1'b1;
                end
            endcase
        end
    end

    // A load hit on the same cycle an IRQ is taken is not counted: that ID instruction is re-fetched after the trap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ld_cnt <= '0;
        end else if (mispredict) begin
            ld_cnt <= '0;
        end else if (ld_cnt != '0) begin
            ld_cnt <= ld_cnt - 4'd1;
        end else if (ld_hit && (state == IDLE) && !irq_take) begin
            ld_cnt <= 4'(LOAD_LAT - 1);
        end
    end

    // Tracks the PC of the instruction in EX, needed for the not-taken resolved target.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_pc <= '0;
        end else if (stall_ID) begin
            ex_pc <= i_id_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            drn_cnt    <= '0;
            epc_q      <= '0;
            busy_q     <= 1'b0;
            epc_wren_q <= 1'b0;
            trap_sel_q <= 1'b0;
            irq_ack_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (irq_take) begin
                        epc_q   <= i_id_pc;
                        drn_cnt <= 3'(IRQ_DRAIN - 1);
                        busy_q  <= 1'b1;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mispredict) begin
                        epc_q <= resolved_pc;
                    end
                    if (drn_cnt == '0) begin
                        epc_wren_q <= 1'b1;
                        state      <= SAVE;
                    end else begin
                        drn_cnt <= drn_cnt - 3'd1;
                    end
                end
                SAVE: begin
                    epc_wren_q <= 1'b0;
                    trap_sel_q <= 1'b1;
                    irq_ack_q  <= 1'b1;
                    state      <= REDIRECT;
                end
                default: begin
                    trap_sel_q <= 1'b0;
                    irq_ack_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_epc_wren = epc_wren_q;
    assign o_trap_sel = trap_sel_q;
    assign o_irq_ack  = irq_ack_q;
    assign o_epc      = epc_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!stall_ID && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!flush_EX && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt;
    assign o_flush_cnt = flush_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule
